// File: rtl/decoder_nx_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder: direct handshake or dwell scan.
// Scan mode is built only when DECODER_NX_SEQ_SCAN_EN is defined.
module decoder_nx_seq #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic                  sel_ready,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int N = 1 << SEL_W;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SCAN
  } state_e;

  state_e             state_q;
  logic [N-1:0]       y_q;
  logic [SEL_W-1:0]   idx_q;
  logic               mode_eff;
  logic               xfer;

`ifdef DECODER_NX_SEQ_SCAN_EN
  logic [DWELL_W-1:0] cnt_q;
  logic [SEL_W-1:0]   idx_d;
  logic               wrap_q;

  assign mode_eff = mode;
  assign idx_d    = idx_q + 1'b1;
  assign wrap     = wrap_q;
`else
  logic unused_scan;

  assign mode_eff    = 1'b0;
  assign wrap        = 1'b0;
  assign unused_scan = ^{mode, dwell};
`endif

  assign sel_ready = enable & ~mode_eff;
  assign xfer      = sel_valid & sel_ready;
  assign y         = y_q;
  assign idx       = idx_q;

`ifdef DECODER_NX_SEQ_SCAN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (!enable) begin
      state_q <= IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (xfer) begin
      // A transfer wins even in the cycle that leaves scan mode.
      state_q <= HOLD;
      idx_q   <= sel;
      y_q     <= ONE << sel;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (mode_eff) begin
      if (state_q != SCAN) begin
        state_q <= SCAN;
        idx_q   <= '0;
        y_q     <= ONE;
        cnt_q   <= dwell;
        wrap_q  <= 1'b0;
      end else if (cnt_q != '0) begin
        cnt_q   <= cnt_q - 1'b1;
        wrap_q  <= 1'b0;
      end else begin
        idx_q   <= idx_d;
        y_q     <= ONE << idx_d;
        cnt_q   <= dwell;
        wrap_q  <= (idx_d == '0);
      end
    end else begin
      wrap_q <= 1'b0;
      if (state_q == SCAN) begin
        state_q <= IDLE;
        y_q     <= '0;
        cnt_q   <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      idx_q   <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
      y_q     <= '0;
    end else if (xfer) begin
      state_q <= HOLD;
      idx_q   <= sel;
      y_q     <= ONE << sel;
    end
  end
`endif

endmodule
